ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_edge_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and receiver.
//   ps2_state_t         - controller state encoding
//   DEF_INHIBIT_CYCLES  - default clock-inhibit time before a request (100 us @ 50 MHz)
//   DEF_TIMEOUT_CYCLES  - default maximum gap between device clock edges (2 ms @ 50 MHz)
//   odd_parity()        - PS/2 parity bit for a data byte
package ps2_pkg;

    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE     = 3'd0;
    localparam ps2_state_t ST_INHIBIT  = 3'd1;
    localparam ps2_state_t ST_REQ      = 3'd2;
    localparam ps2_state_t ST_SEND     = 3'd3;
    localparam ps2_state_t ST_ACK      = 3'd4;
    localparam ps2_state_t ST_WAITIDLE = 3'd5;

    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

    // Parity bit making the total count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: two-flop synchronizer plus falling-edge detector for one PS/2 line.
//   clk, reset  - system clock, synchronous active-high reset (all flops reset to 1, idle line)
//   line_in     - asynchronous sensed line
//   line_sync   - synchronized line level
//   fall        - high for one cycle when line_sync goes 1 -> 0
module ps2_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            prev      <= 1'b1;
        end else begin
            meta      <= line_in;
            line_sync <= meta;
            prev      <= line_sync;
        end
    end

    assign fall = prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//   clk, reset          - system clock, synchronous active-high reset
//   ps2c_in, ps2d_in    - sensed PS/2 clock/data lines (asynchronous)
//   ps2c_oe, ps2d_oe    - registered open-drain enables, 1 pulls the line low
//   start, din          - transmit request and command byte (sampled in idle only)
//   busy                - transfer in progress
//   done                - one-cycle pulse at the end of a transfer
//   err                 - one-cycle pulse with done on missing ack or timeout
// The tristate buffers live in the enclosing top level; only enables are driven here.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    ps2_state_t    state;
    logic [7:0]    data;
    logic          parity;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          nack;

    logic c_sync, c_fall;
    logic d_sync, d_fall_unused;
    logic timeout;

    ps2_edge_sync u_sync_c (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2c_in),
        .line_sync (c_sync),
        .fall      (c_fall)
    );

    ps2_edge_sync u_sync_d (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2d_in),
        .line_sync (d_sync),
        .fall      (d_fall_unused)
    );

    // A device edge arriving in the same cycle as expiry keeps the transfer alive.
    assign timeout = (to_cnt == TO_MAX) && !c_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            data    <= '0;
            parity  <= 1'b0;
            bit_cnt <= '0;
            inh_cnt <= '0;
            to_cnt  <= '0;
            nack    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    if (start) begin
                        data    <= din;
                        parity  <= odd_parity(din);
                        busy    <= 1'b1;
                        inh_cnt <= '0;
                        ps2c_oe <= 1'b1;
                        state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2d_oe <= 1'b1;
                        state   <= ST_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    // Release clock, keep data low as the start bit.
                    ps2c_oe <= 1'b0;
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    nack    <= 1'b0;
                    state   <= ST_SEND;
                end
                ST_SEND, ST_ACK, ST_WAITIDLE: begin
                    if (timeout) begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= c_fall ? '0 : to_cnt + 1'b1;
                        if (state == ST_SEND) begin
                            // bit_cnt holds edges seen so far; this edge is bit_cnt+1.
                            if (c_fall) begin
                                bit_cnt <= bit_cnt + 4'd1;
                                if (bit_cnt < 4'd8) begin
                                    ps2d_oe <= ~data[bit_cnt[2:0]];
                                end else if (bit_cnt == 4'd8) begin
                                    ps2d_oe <= ~parity;
                                end else begin
                                    ps2d_oe <= 1'b0;
                                    state   <= ST_ACK;
                                end
                            end
                        end else if (state == ST_ACK) begin
                            if (c_fall) begin
                                bit_cnt <= bit_cnt + 4'd1;
                                nack    <= d_sync;
                                state   <= ST_WAITIDLE;
                            end
                        end else begin
                            if (c_sync && d_sync) begin
                                done  <= 1'b1;
                                err   <= nack;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural PS/2 device.
// Expected line bits and error flags are queued when a transfer is started and
// popped as the device clocks bits in and when the host reports completion.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned TO   = 300;
    localparam int          HALF = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       ps2c_oe, ps2d_oe, busy, done, err;
    logic       dev_c, dev_d;
    logic       ps2c_line, ps2d_line;

    int vectors = 0;
    int miscompares = 0;

    logic bit_q[$];
    logic err_q[$];

    // Open-drain wired-AND of host and device.
    assign ps2c_line = dev_c & ~ps2c_oe;
    assign ps2d_line = dev_d & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2c_in (ps2c_line),
        .ps2d_in (ps2d_line),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .start   (start),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete host transfer with the device giving `edges` clock pulses.
    // ack=1 makes the device pull data low for edge 11; mid_start re-pulses start
    // with din=0x00 during bit 3.
    task automatic run_xfer(input logic [7:0] b, input bit ack, input int edges, input bit mid_start);
        int   n;
        int   budget;
        logic exp_bit;
        logic exp_err;

        @(negedge clk);
        din   = b;
        start = 1'b1;
        for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
        bit_q.push_back(~^b);
        bit_q.push_back(1'b1);
        err_q.push_back(!(ack && edges == 11));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);

        n = 0;
        while (ps2c_oe === 1'b1 && ps2d_oe === 1'b0 && n < 4 * INH) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("req_c_oe", ps2c_oe, 1);
        check("req_d_oe", ps2d_oe, 1);
        @(negedge clk);
        check("send_c_oe", ps2c_oe, 0);
        check("send_d_oe", ps2d_oe, 1);

        for (int k = 1; k <= edges; k++) begin
            if (k == 11 && ack) dev_d = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_c = 1'b0;
            if (k == 3 && mid_start) begin
                start = 1'b1;
                din   = 8'h00;
            end
            @(negedge clk);
            start = 1'b0;
            repeat (HALF - 1) @(negedge clk);
            dev_c = 1'b1;
            if (k <= 10) begin
                if (bit_q.size() == 0) begin
                    check("bit_queue_empty", 1, 0);
                end else begin
                    exp_bit = bit_q.pop_front();
                    check($sformatf("line_bit%0d_of_%02h", k, b), ps2d_line, exp_bit);
                end
            end
        end
        if (edges == 11 && ack) begin
            repeat (HALF) @(negedge clk);
            check("busy_before_release", busy, 1);
            dev_d = 1'b1;
        end

        budget = (edges == 11) ? 100 : TO + 100;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        exp_err = err_q.pop_front();
        check("done_pulse", done, 1);
        check("err_flag", err, exp_err);
        check("end_c_oe", ps2c_oe, 0);
        check("end_d_oe", ps2d_oe, 0);
        @(negedge clk);
        check("busy_cleared", busy, 0);
        check("done_one_cycle", done, 0);
        bit_q.delete();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        dev_c = 1'b1;
        dev_d = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_c_oe", ps2c_oe, 0);
        check("rst_d_oe", ps2d_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Acked transfers, odd and even parity bytes.
        run_xfer(8'hED, 1'b1, 11, 1'b0);
        run_xfer(8'hF4, 1'b1, 11, 1'b0);
        // Device never acks.
        run_xfer(8'hA5, 1'b0, 11, 1'b0);
        // Device stops clocking after edge 4.
        run_xfer(8'h3C, 1'b1, 4, 1'b0);
        // start during SEND must not disturb the byte in flight.
        run_xfer(8'h5A, 1'b1, 11, 1'b1);

        // Reset during INHIBIT, then a normal transfer.
        @(negedge clk);
        din   = 8'hED;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("inhibit_active", ps2c_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_c_oe", ps2c_oe, 0);
        check("midrst_d_oe", ps2d_oe, 0);
        check("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        run_xfer(8'hED, 1'b1, 11, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
